cache_mem_arbiter: RTL and testbench

- Shares the single physical-memory line port between the I-cache miss path and the D-cache miss/writeback path.
- Sits below both caches. Its i_resp and d_resp outputs become the if_mem_resp and mem_mem_resp inputs seen by hazard detection, so a stalled stage is released only when its own transfer completes.
- Serves one line transfer at a time using a registered grant state machine.

---
 rtl/cache_mem_arbiter_pkg.sv | 24 ++
 rtl/cache_mem_arbiter_if.sv | 37 +++
 rtl/cache_mem_arbiter_prio.sv | 26 ++
 rtl/cache_mem_arbiter.sv | 126 ++++++++++++
 tb/tb_cache_mem_arbiter.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/cache_mem_arbiter_pkg.sv
// Shared types and constants for the cache/memory line-port arbiter.
// Optional round-robin arbitration is enabled by defining CACHE_MEM_ARB_RR_EN.
package mem_arb_pkg;

  localparam int ARB_ADDR_W = 16;
  localparam int ARB_LINE_W = 128;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SERVE_I = 2'd1,
    SERVE_D = 2'd2,
    DONE    = 2'd3
  } arb_state_t;

  typedef enum logic {
    SRC_I = 1'b0,
    SRC_D = 1'b1
  } req_src_t;

  function automatic arb_state_t serve_state(input req_src_t src);
    return (src == SRC_D) ? SERVE_D : SERVE_I;
  endfunction

endpackage

// File: rtl/cache_mem_arbiter_if.sv
// Bundle of I-cache, D-cache and physical-memory line-port signals seen by the arbiter.
// master = arbiter view, slave = caches/memory view.
interface cache_mem_arbiter_if #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) ();

  logic              i_read;
  logic [ADDR_W-1:0] i_addr;
  logic [LINE_W-1:0] i_rdata;
  logic              i_resp;

  logic              d_read;
  logic              d_write;
  logic [ADDR_W-1:0] d_addr;
  logic [LINE_W-1:0] d_wdata;
  logic [LINE_W-1:0] d_rdata;
  logic              d_resp;

  logic              mem_read;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [LINE_W-1:0] mem_wdata;
  logic [LINE_W-1:0] mem_rdata;
  logic              mem_resp;

  modport master (
    input  i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    output i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport slave (
    output i_read, i_addr, d_read, d_write, d_addr, d_wdata, mem_rdata, mem_resp,
    input  i_rdata, i_resp, d_rdata, d_resp, mem_read, mem_write, mem_addr, mem_wdata
  );

endinterface

// File: rtl/cache_mem_arbiter_prio.sv
// Combinational next-source pick for the line-port arbiter.
// RR_EN selects round-robin on contention; otherwise D wins over I.
module arb_priority_sel
  import mem_arb_pkg::*;
#(
  parameter bit RR_EN = 1'b0
) (
  input  logic     i_req,
  input  logic     d_req,
  input  req_src_t last_grant,
  output logic     grant_valid,
  output req_src_t grant_src
);

  always_comb begin
    grant_valid = i_req | d_req;
    grant_src   = SRC_D;
    if (i_req && d_req) begin
      // On contention the older MEM-stage access drains first unless rotating.
      grant_src = (RR_EN && (last_grant == SRC_D)) ? SRC_I : SRC_D;
    end else if (i_req) begin
      grant_src = SRC_I;
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one physical-memory line port between the I-cache and D-cache miss paths.
// Define CACHE_MEM_ARB_RR_EN for round-robin grants on simultaneous requests.
module cache_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W = ARB_ADDR_W,
  parameter int LINE_W = ARB_LINE_W
) (
  input  logic             clk,
  input  logic             rst_n,
  cache_mem_arbiter_if.master bus
);

  localparam logic [1:0] ST_IDLE    = IDLE;
  localparam logic [1:0] ST_SERVE_I = SERVE_I;
  localparam logic [1:0] ST_SERVE_D = SERVE_D;
  localparam logic [1:0] ST_DONE    = DONE;

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              grant_valid;
  req_src_t          grant_src;
  req_src_t          last_grant;
  logic              serving;
  logic              take_grant;

  logic              g_write;
  logic [ADDR_W-1:0] g_addr;
  logic [LINE_W-1:0] g_wdata;

`ifdef CACHE_MEM_ARB_RR_EN
  localparam bit RR_EN = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant <= SRC_I;
    end else if (take_grant) begin
      last_grant <= grant_src;
    end
  end
`else
  localparam bit RR_EN = 1'b0;

  assign last_grant = SRC_I;
`endif

  arb_priority_sel #(
    .RR_EN (RR_EN)
  ) u_prio (
    .i_req       (bus.i_read),
    .d_req       (bus.d_read | bus.d_write),
    .last_grant  (last_grant),
    .grant_valid (grant_valid),
    .grant_src   (grant_src)
  );

  assign take_grant = (state == ST_IDLE) && grant_valid;
  assign serving    = (state == ST_SERVE_I) || (state == ST_SERVE_D);

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: begin
        if (grant_valid) state_nxt = serve_state(grant_src);
      end
      ST_SERVE_I,
      ST_SERVE_D: begin
        if (bus.mem_resp) state_nxt = ST_DONE;
      end
      ST_DONE: begin
        // One dead cycle lets the served cache drop its request before re-arbitration.
        state_nxt = ST_IDLE;
      end
      default: begin
        state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Grant registers: captured once on entry to service, then frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      g_write <= 1'b0;
      g_addr  <= '0;
      g_wdata <= '0;
    end else if (take_grant) begin
      if (grant_src == SRC_D) begin
        g_write <= bus.d_write;
        g_addr  <= bus.d_addr;
        g_wdata <= bus.d_wdata;
      end else begin
        g_write <= 1'b0;
        g_addr  <= bus.i_addr;
        g_wdata <= '0;
      end
    end
  end

  assign bus.mem_read  = serving && !g_write;
  assign bus.mem_write = serving && g_write;
  assign bus.mem_addr  = g_addr;
  assign bus.mem_wdata = g_wdata;

  assign bus.i_resp  = (state == ST_SERVE_I) && bus.mem_resp;
  assign bus.d_resp  = (state == ST_SERVE_D) && bus.mem_resp;
  assign bus.i_rdata = bus.i_resp ? bus.mem_rdata : '0;
  assign bus.d_rdata = bus.d_resp ? bus.mem_rdata : '0;

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (rst_n) begin
      assert (!(bus.d_read && bus.d_write))
        else $error("cache_mem_arbiter: d_read and d_write asserted together");
    end
  end
`endif

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Directed self-checking bench for cache_mem_arbiter (either arbitration build).
module tb_cache_mem_arbiter;
  import mem_arb_pkg::*;

`ifdef CACHE_MEM_ARB_RR_EN
  localparam bit RR = 1'b1;
`else
  localparam bit RR = 1'b0;
`endif

  logic clk;
  logic rst_n;
  int   checks;
  int   failures;

  cache_mem_arbiter_if #(.ADDR_W(16), .LINE_W(128)) bus ();

  cache_mem_arbiter #(.ADDR_W(16), .LINE_W(128)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  logic [127:0] rd1, rd2, rd3, a5, expd;
  logic         first_d, exp_d;

  initial begin
    checks   = 0;
    failures = 0;
    rd1 = 128'h0123_4567_89AB_CDEF_FEDC_BA98_7654_3210;
    rd2 = 128'hDEAD_BEEF_0000_1111_2222_3333_4444_5555;
    rd3 = 128'h1357_9BDF_2468_ACE0_0F0F_F0F0_AAAA_5555;
    a5  = {16{8'hA5}};

    rst_n = 1'b0;
    bus.i_read = 1'b0; bus.i_addr = '0;
    bus.d_read = 1'b0; bus.d_write = 1'b0; bus.d_addr = '0; bus.d_wdata = '0;
    bus.mem_rdata = '0; bus.mem_resp = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_state", 128'(dut.state), 128'(IDLE));
    chk("rst_mem_read", 128'(bus.mem_read), 128'd0);
    chk("rst_mem_write", 128'(bus.mem_write), 128'd0);
    chk("rst_mem_addr", 128'(bus.mem_addr), 128'd0);
    chk("rst_mem_wdata", bus.mem_wdata, 128'd0);
    chk("rst_resps", 128'({bus.i_resp, bus.d_resp}), 128'd0);
    chk("rst_rdata", bus.i_rdata | bus.d_rdata, 128'd0);
    next_cyc();
    rst_n = 1'b1;

    // I-only read, response 5 cycles after the strobe
    bus.i_read = 1'b1; bus.i_addr = 16'h1230;
    @(negedge clk);
    chk("t1_no_strobe_yet", 128'(bus.mem_read), 128'd0);
    next_cyc();
    @(negedge clk);
    chk("t1_mem_read", 128'(bus.mem_read), 128'd1);
    chk("t1_mem_write", 128'(bus.mem_write), 128'd0);
    chk("t1_mem_addr", 128'(bus.mem_addr), 128'h1230);
    for (int i = 0; i < 4; i++) begin
      next_cyc();
      @(negedge clk);
      chk("t1_hold_read", 128'(bus.mem_read), 128'd1);
      chk("t1_no_resp", 128'({bus.i_resp, bus.d_resp}), 128'd0);
    end
    next_cyc();
    bus.mem_resp = 1'b1; bus.mem_rdata = rd1;
    @(negedge clk);
    chk("t1_i_resp", 128'(bus.i_resp), 128'd1);
    chk("t1_i_rdata", bus.i_rdata, rd1);
    chk("t1_d_resp", 128'(bus.d_resp), 128'd0);
    chk("t1_d_rdata", bus.d_rdata, 128'd0);
    next_cyc();
    bus.i_read = 1'b0;  // mem_resp left high: must be ignored in DONE
    @(negedge clk);
    chk("t1_done_state", 128'(dut.state), 128'(DONE));
    chk("t1_done_strobe", 128'(bus.mem_read), 128'd0);
    chk("t1_done_no_resp", 128'({bus.i_resp, bus.d_resp}), 128'd0);
    chk("t1_done_rdata", bus.i_rdata, 128'd0);
    next_cyc();
    bus.mem_resp = 1'b0;
    @(negedge clk);
    chk("t1_idle", 128'(dut.state), 128'(IDLE));

    // D writeback; address/data change mid-service is ignored
    bus.d_write = 1'b1; bus.d_addr = 16'h4000; bus.d_wdata = a5;
    next_cyc();
    @(negedge clk);
    chk("t2_mem_write", 128'(bus.mem_write), 128'd1);
    chk("t2_mem_read", 128'(bus.mem_read), 128'd0);
    chk("t2_mem_addr", 128'(bus.mem_addr), 128'h4000);
    chk("t2_mem_wdata", bus.mem_wdata, a5);
    next_cyc();
    bus.d_addr = 16'h4010; bus.d_wdata = '0;
    @(negedge clk);
    chk("t2_addr_frozen", 128'(bus.mem_addr), 128'h4000);
    chk("t2_wdata_frozen", bus.mem_wdata, a5);
    chk("t2_write_held", 128'(bus.mem_write), 128'd1);
    next_cyc();
    bus.mem_resp = 1'b1; bus.mem_rdata = rd2;
    @(negedge clk);
    chk("t2_d_resp", 128'(bus.d_resp), 128'd1);
    chk("t2_i_resp", 128'(bus.i_resp), 128'd0);
    next_cyc();
    bus.mem_resp = 1'b0; bus.d_write = 1'b0;
    @(negedge clk);
    chk("t2_done_write", 128'(bus.mem_write), 128'd0);
    next_cyc();

    // Simultaneous I and D reads; last served was D
    first_d = !RR;
    bus.i_read = 1'b1; bus.i_addr = 16'h2000;
    bus.d_read = 1'b1; bus.d_addr = 16'h3000;
    next_cyc();
    @(negedge clk);
    chk("t3_first_read", 128'(bus.mem_read), 128'd1);
    chk("t3_first_addr", 128'(bus.mem_addr), first_d ? 128'h3000 : 128'h2000);
    next_cyc();
    bus.mem_resp = 1'b1; bus.mem_rdata = rd3;
    @(negedge clk);
    chk("t3_first_d_resp", 128'(bus.d_resp), 128'(first_d));
    chk("t3_first_i_resp", 128'(bus.i_resp), 128'(!first_d));
    chk("t3_first_rdata", first_d ? bus.d_rdata : bus.i_rdata, rd3);
    next_cyc();
    bus.mem_resp = 1'b0;
    if (first_d) bus.d_read = 1'b0; else bus.i_read = 1'b0;
    @(negedge clk);
    chk("t3_gap1_read", 128'(bus.mem_read), 128'd0);
    next_cyc();
    @(negedge clk);
    chk("t3_gap2_read", 128'(bus.mem_read), 128'd0);
    next_cyc();
    @(negedge clk);
    chk("t3_second_read", 128'(bus.mem_read), 128'd1);
    chk("t3_second_addr", 128'(bus.mem_addr), first_d ? 128'h2000 : 128'h3000);
    next_cyc();
    bus.mem_resp = 1'b1; bus.mem_rdata = rd1;
    @(negedge clk);
    chk("t3_second_i_resp", 128'(bus.i_resp), 128'(first_d));
    chk("t3_second_d_resp", 128'(bus.d_resp), 128'(!first_d));
    next_cyc();
    bus.mem_resp = 1'b0; bus.i_read = 1'b0; bus.d_read = 1'b0;
    next_cyc();

    // Both held for 4 transfers: alternate with rotation, D every time otherwise
    bus.i_read = 1'b1; bus.i_addr = 16'h5000;
    bus.d_read = 1'b1; bus.d_addr = 16'h6000;
    for (int k = 0; k < 4; k++) begin
      exp_d = RR ? k[0] : 1'b1;
      expd  = exp_d ? 128'h6000 : 128'h5000;
      next_cyc();
      @(negedge clk);
      chk("t4_grant_addr", 128'(bus.mem_addr), expd);
      next_cyc();
      bus.mem_resp = 1'b1; bus.mem_rdata = rd2;
      @(negedge clk);
      chk("t4_d_resp", 128'(bus.d_resp), 128'(exp_d));
      chk("t4_i_resp", 128'(bus.i_resp), 128'(!exp_d));
      next_cyc();
      bus.mem_resp = 1'b0;
      next_cyc();
    end
    bus.i_read = 1'b0; bus.d_read = 1'b0;
    next_cyc();

    // Asynchronous reset two cycles into SERVE_I, then re-grant of held request
    bus.i_read = 1'b1; bus.i_addr = 16'h5550;
    next_cyc();
    @(negedge clk);
    chk("t5_serving", 128'(bus.mem_read), 128'd1);
    next_cyc();
    #2;
    rst_n = 1'b0;
    bus.mem_resp = 1'b1;
    #1;
    chk("t5_strobe_drop", 128'(bus.mem_read), 128'd0);
    chk("t5_no_i_resp", 128'(bus.i_resp), 128'd0);
    chk("t5_rst_state", 128'(dut.state), 128'(IDLE));
    next_cyc();
    bus.mem_resp = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    chk("t5_post_rst_idle", 128'(dut.state), 128'(IDLE));
    next_cyc();
    @(negedge clk);
    chk("t5_regrant_read", 128'(bus.mem_read), 128'd1);
    chk("t5_regrant_addr", 128'(bus.mem_addr), 128'h5550);
    next_cyc();
    bus.mem_resp = 1'b1; bus.mem_rdata = rd3;
    @(negedge clk);
    chk("t5_i_resp", 128'(bus.i_resp), 128'd1);
    next_cyc();
    bus.mem_resp = 1'b0; bus.i_read = 1'b0;
    repeat (2) next_cyc();

    // Spurious mem_resp while IDLE
    bus.mem_resp = 1'b1; bus.mem_rdata = rd1;
    @(negedge clk);
    chk("t6_no_resp", 128'({bus.i_resp, bus.d_resp}), 128'd0);
    chk("t6_no_rdata", bus.i_rdata | bus.d_rdata, 128'd0);
    next_cyc();
    bus.mem_resp = 1'b0;
    @(negedge clk);
    chk("t6_state_idle", 128'(dut.state), 128'(IDLE));
    chk("t6_no_strobe", 128'({bus.mem_read, bus.mem_write}), 128'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
